// File: rtl/adder_pkg.sv
// Shared constants and type helpers for the adder_unit datapath.
// Consumers size operands with WIDTH and sums with WIDTH+1.
package adder_pkg;

    localparam int unsigned ADDER_DEFAULT_WIDTH = 32;

    typedef logic [ADDER_DEFAULT_WIDTH-1:0] adder_operand_t;
    typedef logic [ADDER_DEFAULT_WIDTH:0]   adder_sum_t;

    function automatic int unsigned adder_sum_width(input int unsigned operand_width);
        return operand_width + 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell, the building block of the adder_unit ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/adder_unit.sv
// Unsigned WIDTH-bit ripple-carry adder with a single registered WIDTH+1-bit result.
// Define ADDER_TRACE_EN to print each new sum (decimal and binary) in simulation.
module adder_unit
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH:0]   OUT
);

    typedef logic [WIDTH-1:0] operand_t;
    typedef logic [WIDTH:0]   sum_t;

    logic [WIDTH:0] carry;
    operand_t       sum_bits;
    sum_t           sum_d;
    sum_t           out_q;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    // Carry out of the top cell becomes the sum MSB.
    assign sum_d = {carry[WIDTH], sum_bits};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= sum_d;
        end
    end

    assign OUT = out_q;

`ifdef ADDER_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            $display("adder_unit: A=%0d B=%0d SUM=%0d", A, B, sum_d);
            $display("adder_unit: A=%b B=%b SUM=%b", A, B, sum_d);
        end
    end
`endif

endmodule

// File: tb/tb_adder_unit.sv
// Self-checking bench for adder_unit: directed corner cases plus randomized operands
// compared against a 64-bit arithmetic reference with one cycle of latency.
`timescale 1ns/1ps
module tb_adder_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W:0]   OUT;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [63:0] prev_exp;
    bit          have_prev;

    adder_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .OUT (OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus; check OUT still holds the previous result before
    // the edge and the new one after it.
    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input bit r,
                         input string tag);
        logic [63:0] exp;
        A   = a;
        B   = b;
        rst = r;
        #1;
        if (have_prev) check_eq({tag, "_hold"}, {31'd0, OUT}, prev_exp);
        exp = r ? 64'd0 : (64'(a) + 64'(b));
        @(posedge clk);
        #1;
        check_eq(tag, {31'd0, OUT}, exp);
        prev_exp  = exp;
        have_prev = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           rr;

        n_checks  = 0;
        n_errors  = 0;
        have_prev = 1'b0;
        prev_exp  = '0;
        rst = 1'b1;
        A   = '0;
        B   = '0;

        apply(32'd7, 32'd9, 1'b1, "reset0");
        apply(32'd7, 32'd9, 1'b1, "reset1");
        apply(32'd7, 32'd9, 1'b0, "reset_release");

        apply(32'd3, 32'd5, 1'b0, "basic");

        apply(32'hFFFF_FFFF, 32'd1,        1'b0, "carry_one");
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "carry_max");
        check_eq("carry_max_value", {31'd0, OUT}, 64'h1_FFFF_FFFE);

        ta = '{32'd1, 32'd10, 32'd0, 32'h8000_0000};
        tb = '{32'd2, 32'd20, 32'd0, 32'h8000_0000};
        for (int i = 0; i < 4; i++) apply(ta[i], tb[i], 1'b0, "b2b");

        apply(32'd100, 32'd200, 1'b1, "midreset");
        apply(32'd100, 32'd200, 1'b0, "midreset_release");
        check_eq("midreset_value", {31'd0, OUT}, 64'd300);

        for (int i = 0; i < 10000; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            rr = ($urandom_range(0, 63) == 0);
            apply(ra, rb, rr, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
